// File: rtl/aes_round_sequencer.sv
// ============================================================================
//  Module   : aes_round_sequencer
//  Purpose  : Round/byte-slot control FSM for a byte-serial AES-128 encrypt
//             datapath, with round-key handshake and ShiftRows stall watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer #(
    parameter int NUM_ROUNDS      = 10,
    parameter int BYTES_PER_BLOCK = 16,
    parameter int SR_TIMEOUT      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       key_ack_i,
    input  logic       sr_ready_i,
    output logic       busy_o,
    output logic       key_req_o,
    output logic       issue_valid_o,
    output logic       sel_input_o,
    output logic [3:0] byte_idx_o,
    output logic [3:0] round_o,
    output logic       mc_bypass_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int         WD_W         = $clog2(SR_TIMEOUT);
    localparam logic [3:0] C_LAST_IDX   = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [4:0] C_BEATS      = 5'(BYTES_PER_BLOCK);
    localparam logic [WD_W-1:0] C_WD_LIMIT = WD_W'(SR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_INIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [3:0]      idx_q,   idx_d;
    logic [4:0]      ret_q,   ret_d;
    logic [WD_W-1:0] wd_q,    wd_d;

    logic w_beat;
    logic w_round_complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            idx_q   <= 4'd0;
            ret_q   <= 5'd0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            ret_q   <= ret_d;
            wd_q    <= wd_d;
        end
    end

    // Return beats saturate at one block's worth; surplus beats are dropped.
    assign w_beat = sr_ready_i && (ret_q != C_BEATS);

    // A round may already hold all its beats on DRAIN entry; finish it then too.
    assign w_round_complete = (ret_q == C_BEATS) ||
                              (w_beat && (ret_q == (C_BEATS - 5'd1)));

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        ret_d   = ret_q;
        wd_d    = wd_q;

        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                idx_d   = 4'd0;
                ret_d   = 5'd0;
                wd_d    = '0;
                if (start_i) begin
                    state_d = S_KEY;
                end
            end

            S_KEY: begin
                if (key_ack_i) begin
                    idx_d   = 4'd0;
                    ret_d   = 5'd0;
                    state_d = (round_q == 4'd0) ? S_INIT : S_ISSUE;
                end
            end

            S_INIT: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == C_LAST_IDX) begin
                    idx_d   = 4'd0;
                    round_d = 4'd1;
                    state_d = S_KEY;
                end
            end

            S_ISSUE: begin
                idx_d = idx_q + 4'd1;
                if (w_beat) begin
                    ret_d = ret_q + 5'd1;
                end
                if (idx_q == C_LAST_IDX) begin
                    idx_d   = 4'd0;
                    wd_d    = '0;
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (w_beat) begin
                    ret_d = ret_q + 5'd1;
                end
                wd_d = sr_ready_i ? '0 : (wd_q + WD_W'(1));
                if (w_round_complete) begin
                    if (round_q == C_LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_KEY;
                    end
                end else if (!sr_ready_i && (wd_q == C_WD_LIMIT)) begin
                    state_d = S_ERR;
                end
            end

            S_DONE, S_ERR: begin
                round_d = 4'd0;
                idx_d   = 4'd0;
                ret_d   = 5'd0;
                wd_d    = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o        = (state_q != S_IDLE);
        key_req_o     = (state_q == S_KEY);
        issue_valid_o = (state_q == S_INIT) || (state_q == S_ISSUE);
        sel_input_o   = (state_q == S_INIT);
        mc_bypass_o   = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                        (round_q == C_LAST_ROUND);
        done_o        = (state_q == S_DONE);
        err_o         = (state_q == S_ERR);
        byte_idx_o    = idx_q;
        round_o       = round_q;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the byte-serial AES-128 encryption datapath (AddRoundKey -> SubBytes -> byte-serial ShiftRows -> MixColumns, 8-bit lanes).
- Issues 16 byte slots per round, fetches round keys by handshake and counts returned ShiftRows output beats to detect round completion.
- Sequences round 0 (AddRoundKey only), rounds 1..NUM_ROUNDS-1, and the final round with MixColumns bypassed.
- Has a watchdog that aborts if the ShiftRows stage stalls.

Parameters:
- NUM_ROUNDS, 10: number of full rounds; final round index.
- BYTES_PER_BLOCK, 16: byte slots per round.
- SR_TIMEOUT, 32: maximum cycles with no sr_ready while in DRAIN before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- key_ack  in  1  round key for current round is valid.
- sr_ready  in  1  ShiftRows stage presents one valid output byte this cycle.
- busy  out  1  high in every state except IDLE.
- key_req  out  1  level request for the round key of `round`.
- issue_valid  out  1  datapath consumes one byte this cycle.
- sel_input  out  1  1 = plaintext byte stream, 0 = round feedback.
- byte_idx  out  4  index of byte issued this cycle (0..15).
- round  out  4  current round (0..NUM_ROUNDS).
- mc_bypass  out  1  skip MixColumns (final round).
- done  out  1  one-cycle pulse, block complete.
- err  out  1  one-cycle pulse, watchdog abort.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; every output = 0.
  - round = 0, byte_idx = 0, ret_cnt = 0, wd = 0.
- States: IDLE, KEY, INIT, ISSUE, DRAIN, DONE, ERR. All outputs are registered or decoded from state only; none depends combinationally on inputs.
- IDLE:
  - start = 1 -> KEY with round = 0.
  - start while busy is ignored; there is no queueing.
- KEY:
  - key_req = 1 throughout.
  - Exit at the clock edge where key_ack = 1: to INIT if round = 0, else to ISSUE.
  - byte_idx and ret_cnt are cleared on exit.
  - key_ack outside KEY is ignored.
- INIT:
  - issue_valid = 1, sel_input = 1; byte_idx increments every cycle.
  - At byte_idx = 15: round <= 1, then -> KEY.
  - sr_ready is ignored in this state.
- ISSUE:
  - issue_valid = 1, sel_input = 0; byte_idx increments every cycle.
  - At byte_idx = 15 -> DRAIN.
  - Each sr_ready increments ret_cnt (5-bit).
- DRAIN:
  - issue_valid = 0; sr_ready keeps incrementing ret_cnt.
  - On the beat that makes ret_cnt = 16: if round = NUM_ROUNDS -> DONE, else round <= round+1 and -> KEY.
  - wd is cleared on DRAIN entry and on every sr_ready, otherwise increments. If wd reaches SR_TIMEOUT-1 with no sr_ready -> ERR.
- mc_bypass = 1 only in ISSUE/DRAIN with round = NUM_ROUNDS.
- DONE: done = 1 for one cycle; round still reads NUM_ROUNDS; then -> IDLE with round <= 0.
- ERR: err = 1 for one cycle; then -> IDLE with round <= 0 and all counters cleared.
- byte_idx holds 0 whenever issue_valid = 0.
- A round never completes inside ISSUE, even if 16 beats have arrived; completion is evaluated only in DRAIN.
- sr_ready beats beyond 16 in a round are ignored.
- Per round: 1 KEY cycle (with key_ack immediate) + 16 ISSUE cycles + DRAIN cycles until the 16th return beat.

Test Plan:
- Nominal block:
  - Stimulus: key_ack tied 1; ShiftRows model asserts sr_ready for 16 consecutive cycles starting 5 cycles after the first ISSUE cycle; start pulsed.
  - Required: first KEY cycle = cycle 0, INIT in cycles 1..16; round r (r = 1..10) KEY at cycle 17+22(r-1); done pulses at cycle 237; exactly 11 key_req episodes; issue_valid high for 176 cycles total.
- Final round flags: during the nominal run, mc_bypass = 1 only across round 10 ISSUE/DRAIN (cycles 216..236); sel_input = 1 only in cycles 1..16.
- Key stall: key_ack held 0 for 7 cycles in round 3 KEY -> FSM stays in KEY with key_req = 1 and issue_valid = 0; done is delayed by exactly 7 cycles (cycle 244).
- Watchdog: sr_ready never asserted in round 1 -> err pulses exactly once, SR_TIMEOUT cycles after DRAIN entry; busy = 0 and round = 0 on the following cycle; no done.
- Ignored start / reset: start pulsed mid-round 4 -> no effect, done still at cycle 237. rst asserted mid-ISSUE of round 6 -> all outputs 0 immediately, without waiting for a clock edge; a new start then gives a full 237-cycle run.
